// File: rtl/vdmem_pkg.sv
// Shared types and defaults for the vector data memory arbiter.
package vdmem_pkg;

  localparam int VD_LANES = 4;
  localparam int VD_DW    = 32 * VD_LANES;
  localparam int VD_AW    = 8;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_t;

  // Index width that stays at least one bit for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vdmem_arbiter_if.sv
// Requester-side and memory-side signals of the vector data memory arbiter.
interface vdmem_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int LANES = 4,
  parameter int AW    = 8
);
  localparam int DW = 32 * LANES;

  // Handshake: requester i transfers when req_valid[i] && req_ready[i] in the same
  // cycle; valid/we/lock/addr/wdata stay stable until then, and ready may depend
  // combinationally on valid but never the other way round.
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      logic [IW-1:0] idx;
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = IW'(j);
      if (!o_any && i_req[idx]) begin
        o_any        = 1'b1;
        o_idx        = idx;
        o_grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vdmem_arbiter.sv
// Round-robin arbiter sharing one vector data memory port, with bounded lock
// sequences and routing of 1-cycle read responses back to the issuer.
module vdmem_arbiter
  import vdmem_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LANES    = VD_LANES,
  parameter int AW       = VD_AW,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  vdmem_arbiter_if.slave    bus,
  output arb_state_t        o_dbg_state
);

  localparam int DW      = 32 * LANES;
  localparam int IW      = idx_w(NREQ);
  localparam int CW      = idx_w(MAX_LOCK + 1);
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  arb_state_t    r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_lock_owner;
  logic [CW-1:0] r_lock_cnt;
  logic          r_rsp_pend;
  logic [IW-1:0] r_rsp_id;

  logic [NREQ-1:0] w_owner_oh;
  logic [NREQ-1:0] w_rsp_oh;
  logic [NREQ-1:0] w_pick_req;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic            w_any;
  logic            w_g_we;
  logic            w_g_lock;
  logic            w_owner_valid;
  logic            w_owner_lock;
  logic [CW-1:0]   w_cnt_next;
  logic [IW-1:0]   w_ptr_next;

  // While locked, only the owner's request is visible to the picker.
  always_comb begin
    w_owner_oh               = '0;
    w_owner_oh[r_lock_owner] = 1'b1;
    w_rsp_oh                 = '0;
    w_rsp_oh[r_rsp_id]       = 1'b1;
    w_pick_req = (r_state == ARB_LOCKED) ? (bus.req_valid & w_owner_oh) : bus.req_valid;
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req   (w_pick_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_g_we        = bus.req_we[w_gidx];
  assign w_g_lock      = bus.req_lock[w_gidx];
  assign w_owner_valid = bus.req_valid[r_lock_owner];
  assign w_owner_lock  = bus.req_lock[r_lock_owner];
  assign w_cnt_next    = r_lock_cnt + CW'(1);
  assign w_ptr_next    = (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + IW'(1);

  assign bus.req_ready = reset ? '0 : w_grant;
  assign bus.mem_we    = !reset && w_any && w_g_we;
  assign bus.mem_addr  = bus.req_addr[w_gidx*AW +: AW];
  assign bus.mem_wdata = bus.req_wdata[w_gidx*DW +: DW];
  assign bus.rsp_valid = (r_rsp_pend && !reset) ? w_rsp_oh : '0;
  assign bus.rsp_rdata = bus.mem_rdata;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARB_UNLOCKED;
      r_rr_ptr     <= '0;
      r_lock_owner <= '0;
      r_lock_cnt   <= '0;
      r_rsp_pend   <= 1'b0;
      r_rsp_id     <= '0;
    end else begin
      r_rsp_pend <= w_any && !w_g_we;
      r_rsp_id   <= w_gidx;
      if (w_any) r_rr_ptr <= w_ptr_next;
      case (r_state)
        ARB_UNLOCKED: begin
          if (w_any && w_g_lock && LOCK_EN) begin
            r_state      <= ARB_LOCKED;
            r_lock_owner <= w_gidx;
            r_lock_cnt   <= CW'(1);
          end
        end
        ARB_LOCKED: begin
          // An owner that goes idle forfeits the lock; that cycle grants nobody.
          if (!w_owner_valid) begin
            r_state    <= ARB_UNLOCKED;
            r_lock_cnt <= '0;
          end else if (!w_owner_lock || w_cnt_next >= CW'(MAX_LOCK)) begin
            r_state    <= ARB_UNLOCKED;
            r_lock_cnt <= '0;
          end else begin
            r_lock_cnt <= w_cnt_next;
          end
        end
        default: r_state <= ARB_UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_vdmem_arbiter.sv
// Bench for vdmem_arbiter: directed scenarios plus random traffic against a reference model.
module tb_vdmem_arbiter;
  import vdmem_pkg::*;

  localparam int NREQ     = 4;
  localparam int LANES    = 4;
  localparam int AW       = 8;
  localparam int MAX_LOCK = 4;
  localparam int DW       = 32 * LANES;

  logic       clk;
  logic       reset;
  arb_state_t dbg_state;

  vdmem_arbiter_if #(.NREQ(NREQ), .LANES(LANES), .AW(AW)) bus ();

  vdmem_arbiter #(
    .NREQ     (NREQ),
    .LANES    (LANES),
    .AW       (AW),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory environment ----------------
  function automatic logic [DW-1:0] init_word(input int a);
    logic [DW-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*32 +: 32] = 32'(a - 4 - l);
    return w;
  endfunction

  function automatic logic [DW-1:0] lanes_inc(input logic [DW-1:0] d);
    logic [DW-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*32 +: 32] = d[l*32 +: 32] + 32'd1;
    return w;
  endfunction

  logic [DW-1:0] mem [256];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0]      ref_mem [256];
  logic [NREQ+DW-1:0] exp_q [$];
  int  m_ptr, m_owner, m_len;
  bit  m_locked;
  int  last_g;
  int  n_asserts = 0;
  int  n_fail    = 0;
  logic [NREQ-1:0] dut_ready;
  logic [NREQ-1:0] dut_rsp_valid;
  logic [DW-1:0]   dut_rsp_rdata;
  logic            dut_mem_we;

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int model_grant();
    if (m_locked) return bus.req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input bit v, input bit we, input bit lk, input int a,
                         input logic [DW-1:0] d);
    bus.req_valid[i]           = v;
    bus.req_we[i]              = we;
    bus.req_lock[i]            = lk;
    bus.req_addr[i*AW +: AW]   = AW'(a);
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic step();
    int g;
    logic [NREQ+DW-1:0] e;
    #1;
    g             = model_grant();
    dut_ready     = bus.req_ready;
    dut_mem_we    = bus.mem_we;
    dut_rsp_valid = bus.rsp_valid;
    dut_rsp_rdata = bus.rsp_rdata;
    check("req_ready", bus.req_ready, oh(g));
    check("locked", dbg_state == ARB_LOCKED, m_locked);
    if (g >= 0) begin
      check("mem_we", bus.mem_we, bus.req_we[g]);
      check("mem_addr", bus.mem_addr, bus.req_addr[g*AW +: AW]);
      if (bus.req_we[g]) check("mem_wdata", bus.mem_wdata, bus.req_wdata[g*DW +: DW]);
    end else begin
      check("mem_we_idle", bus.mem_we, 1'b0);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_valid", bus.rsp_valid, e[NREQ+DW-1:DW]);
      check("rsp_rdata", bus.rsp_rdata, e[DW-1:0]);
    end else begin
      check("rsp_valid_idle", bus.rsp_valid, '0);
    end
    last_g = g;
    @(posedge clk);
    if (g >= 0) begin
      if (bus.req_we[g]) ref_mem[bus.req_addr[g*AW +: AW]] = bus.req_wdata[g*DW +: DW];
      else exp_q.push_back({oh(g), ref_mem[bus.req_addr[g*AW +: AW]]});
      m_ptr = (g + 1) % NREQ;
      if (m_locked) begin
        m_len++;
        if (!bus.req_lock[g] || m_len >= MAX_LOCK) m_locked = 0;
      end else if (bus.req_lock[g] && MAX_LOCK > 1) begin
        m_locked = 1;
        m_owner  = g;
        m_len    = 1;
      end
    end else begin
      m_locked = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      check("rst_ready", bus.req_ready, '0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, '0);
      @(posedge clk);
      @(negedge clk);
    end
    reset    = 1'b0;
    m_ptr    = 0;
    m_locked = 0;
    m_len    = 0;
    exp_q.delete();
    for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rd;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    @(negedge clk);
    do_reset(2);

    // Single read by requester 2.
    set_req(2, 1, 0, 0, 8, '0);
    step();
    check("t1_ready", dut_ready, 4'b0100);
    clear_all();
    step();
    check("t1_rsp_valid", dut_rsp_valid, 4'b0100);
    check("t1_rsp_rdata", dut_rsp_rdata, {32'd1, 32'd2, 32'd3, 32'd4});

    // Fairness from rr_ptr = 0.
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 16 + i, '0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_order", dut_ready, oh(k % NREQ));
    end
    clear_all();
    step();

    // Lock with forced release after MAX_LOCK grants.
    set_req(0, 1, 0, 0, 30, '0);
    step();
    set_req(1, 1, 0, 1, 20, '0);
    set_req(0, 1, 0, 0, 21, '0);
    set_req(3, 1, 0, 0, 23, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_locked_grant", dut_ready, 4'b0010);
    end
    step();
    check("t3_after_release", dut_ready, 4'b1000);
    clear_all();
    step();

    // Owner drops valid while locked.
    set_req(2, 1, 0, 1, 40, '0);
    step();
    set_req(2, 0, 0, 1, 40, '0);
    set_req(0, 1, 0, 0, 41, '0);
    step();
    check("t4_idle_ready", dut_ready, '0);
    check("t4_idle_we", dut_mem_we, 1'b0);
    step();
    check("t4_resume", dut_ready, 4'b0001);
    clear_all();
    step();

    // Read-modify-write under lock with a competing reader.
    do_reset(1);
    set_req(0, 1, 0, 1, 9, '0);
    set_req(1, 1, 0, 0, 9, '0);
    step();
    check("t5_ready_a", dut_ready, 4'b0001);
    rd = bus.rsp_rdata;
    set_req(0, 1, 1, 0, 9, lanes_inc(rd));
    step();
    check("t5_ready_b", dut_ready, 4'b0001);
    set_req(0, 0, 0, 0, 9, '0);
    step();
    check("t5_ready_c", dut_ready, 4'b0010);
    set_req(1, 0, 0, 0, 9, '0);
    step();
    check("t5_rsp_valid", dut_rsp_valid, 4'b0010);
    check("t5_rsp_rdata", dut_rsp_rdata, {32'd3, 32'd4, 32'd5, 32'd6});

    // Reset right after a read acceptance.
    set_req(2, 1, 0, 0, 12, '0);
    step();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 50 + i, '0);
    do_reset(2);
    for (int k = 0; k < NREQ; k++) begin
      step();
      check("t6_restart", dut_ready, oh(k));
    end
    clear_all();
    step();

    // Random traffic: each requester holds its request until accepted.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15), {$urandom(), $urandom(), $urandom(), $urandom()});
      end
      step();
      if (last_g >= 0) bus.req_valid[last_g] = 1'b0;
    end
    clear_all();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
